// File: rtl/r_layer_ctrl.sv
// Layer/iteration sequencer for the layered QC-LDPC decoder R-message memory.
// Optional early termination on syndrome_ok: define R_EARLY_TERM_EN.
module r_layer_ctrl #(
  parameter int LAYERS   = 16,
  parameter int MAX_ITER = 10,
  parameter int CNU_LAT  = 3,
  parameter int ITER_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              syndrome_ok,
  output logic              rst_r,
  output logic              load_to_CNU,
  output logic              storage,
  output logic              f_one_iteration,
  output logic [3:0]        layer,
  output logic [ITER_W-1:0] iter_cnt,
  output logic              busy,
  output logic              done,
  output logic              decode_ok
);

  localparam int CW = (CNU_LAT > 1) ? $clog2(CNU_LAT) : 1;
  localparam logic [CW-1:0] WAIT_INIT = CW'(CNU_LAT - 1);
  localparam logic [3:0] LAST_LAYER = 4'(LAYERS - 1);
  localparam logic [ITER_W-1:0] LAST_ITER = ITER_W'(MAX_ITER - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_LOAD,
    S_WAIT,
    S_STORE,
    S_ITER_END,
    S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [3:0]        layer_q, layer_d;
  logic [ITER_W-1:0] iter_q, iter_d;
  logic [CW-1:0]     wcnt_q, wcnt_d;
  logic              dok_q, dok_d;
  logic              term_early;

`ifdef R_EARLY_TERM_EN
  assign term_early = syndrome_ok;
`else
  logic unused_syndrome;
  assign unused_syndrome = syndrome_ok;
  assign term_early = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      layer_q <= '0;
      iter_q  <= '0;
      wcnt_q  <= '0;
      dok_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      layer_q <= layer_d;
      iter_q  <= iter_d;
      wcnt_q  <= wcnt_d;
      dok_q   <= dok_d;
    end
  end

  always_comb begin
    state_d = state_q;
    layer_d = layer_q;
    iter_d  = iter_q;
    wcnt_d  = wcnt_q;
    dok_d   = dok_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_CLEAR;
          dok_d   = 1'b0;
        end
      end
      S_CLEAR: begin
        layer_d = '0;
        iter_d  = '0;
        state_d = S_LOAD;
      end
      S_LOAD: begin
        wcnt_d  = WAIT_INIT;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (wcnt_q == '0) state_d = S_STORE;
        else              wcnt_d  = wcnt_q - 1'b1;
      end
      S_STORE: begin
        if (layer_q == LAST_LAYER) begin
          state_d = S_ITER_END;
        end else begin
          layer_d = layer_q + 4'd1;
          state_d = S_LOAD;
        end
      end
      S_ITER_END: begin
        layer_d = '0;
        iter_d  = iter_q + 1'b1;
        if (iter_q == LAST_ITER || term_early) begin
          state_d = S_DONE;
          dok_d   = term_early;
        end else begin
          state_d = S_LOAD;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // abort freezes the datapath and drops straight back to idle
    if (abort) begin
      state_d = S_IDLE;
      layer_d = layer_q;
      iter_d  = iter_q;
      wcnt_d  = wcnt_q;
      dok_d   = dok_q;
    end
  end

  assign rst_r           = (state_q != S_CLEAR);
  assign load_to_CNU     = (state_q == S_LOAD);
  assign storage         = (state_q == S_STORE);
  assign f_one_iteration = (state_q == S_ITER_END);
  assign busy            = (state_q != S_IDLE);
  assign done            = (state_q == S_DONE);
  assign layer           = layer_q;
  assign iter_cnt        = iter_q;
  assign decode_ok       = dok_q;

endmodule

// File: tb/tb_r_layer_ctrl.sv
// Bench for r_layer_ctrl: two instances (MAX_ITER 2 and 10) share stimulus
// and are checked every cycle against a cycle-position reference model.
module tb_r_layer_ctrl;

  localparam int CNU_LAT = 3;
  localparam int LAYERS  = 16;
  localparam int LP      = CNU_LAT + 2;
  localparam int IT      = LAYERS * LP + 1;
`ifdef R_EARLY_TERM_EN
  localparam bit ET = 1'b1;
`else
  localparam bit ET = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start, abort, syn;
  logic [1:0] rst_r, ld, st, f1, busy, done, dok;
  logic [3:0] layer [2];
  logic [3:0] iter [2];

  r_layer_ctrl #(.LAYERS(LAYERS), .MAX_ITER(2), .CNU_LAT(CNU_LAT), .ITER_W(4))
  u_dut2 (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .syndrome_ok(syn), .rst_r(rst_r[0]), .load_to_CNU(ld[0]),
    .storage(st[0]), .f_one_iteration(f1[0]), .layer(layer[0]),
    .iter_cnt(iter[0]), .busy(busy[0]), .done(done[0]),
    .decode_ok(dok[0])
  );

  r_layer_ctrl #(.LAYERS(LAYERS), .MAX_ITER(10), .CNU_LAT(CNU_LAT), .ITER_W(4))
  u_dut10 (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .syndrome_ok(syn), .rst_r(rst_r[1]), .load_to_CNU(ld[1]),
    .storage(st[1]), .f_one_iteration(f1[1]), .layer(layer[1]),
    .iter_cnt(iter[1]), .busy(busy[1]), .done(done[1]),
    .decode_ok(dok[1])
  );

  int mx[2] = '{2, 10};

  // model: run active, cycle index k in run (1 = clear), k of done cycle
  bit         act[2] = '{0, 0};
  int         k[2]   = '{0, 0};
  int         fin[2] = '{0, 0};
  logic [3:0] lm[2]  = '{4'd0, 4'd0};
  logic [3:0] im[2]  = '{4'd0, 4'd0};
  bit         dk[2]  = '{0, 0};

  int n_ld[2], n_st[2], n_f1[2], n_busy[2], n_rr[2], n_done[2];
  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [14:0] expv(int i);
    logic rr, l, s, f, b, d;
    logic [3:0] ly, it;
    int j, r;
    rr = 1'b1; l = 1'b0; s = 1'b0; f = 1'b0; b = 1'b0; d = 1'b0;
    ly = lm[i]; it = im[i];
    if (act[i]) begin
      b = 1'b1;
      if (k[i] == 1) begin
        rr = 1'b0;
      end else if (k[i] == fin[i]) begin
        d = 1'b1; ly = 4'd0; it = 4'((k[i] - 2) / IT);
      end else begin
        j = k[i] - 2;
        r = j % IT;
        it = 4'(j / IT);
        if (r == IT - 1) begin
          f = 1'b1; ly = 4'(LAYERS - 1);
        end else begin
          ly = 4'(r / LP);
          l = (r % LP == 0);
          s = (r % LP == LP - 1);
        end
      end
    end
    return {rr, l, s, f, b, d, dk[i], ly, it};
  endfunction

  always @(negedge clk) begin
    logic [14:0] e;
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        e = expv(i);
        chk(i == 0 ? "dut2_outs" : "dut10_outs",
            {17'd0, rst_r[i], ld[i], st[i], f1[i], busy[i], done[i],
             dok[i], layer[i], iter[i]}, {17'd0, e});
        lm[i] = e[7:4];
        im[i] = e[3:0];
        n_ld[i] += int'(ld[i]);
        n_st[i] += int'(st[i]);
        n_f1[i] += int'(f1[i]);
        n_busy[i] += int'(busy[i]);
        n_rr[i] += int'(!rst_r[i]);
        n_done[i] += int'(done[i]);
      end
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        act[i] = 1'b0; lm[i] = 4'd0; im[i] = 4'd0; dk[i] = 1'b0;
      end else if (act[i]) begin
        if (abort || k[i] == fin[i]) begin
          act[i] = 1'b0;
        end else begin
          if (k[i] >= 2 && (k[i] - 2) % IT == IT - 1) begin
            if ((k[i] - 2) / IT + 1 == mx[i] || (ET && syn)) begin
              fin[i] = k[i] + 1;
              dk[i] = ET && syn;
            end
          end
          k[i]++;
        end
      end else if (start && !abort) begin
        act[i] = 1'b1; k[i] = 1; fin[i] = 0; dk[i] = 1'b0;
      end
    end
  end

  task automatic step(int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic clr_cnt();
    n_ld = '{0, 0}; n_st = '{0, 0}; n_f1 = '{0, 0};
    n_busy = '{0, 0}; n_rr = '{0, 0}; n_done = '{0, 0};
  endtask

  task automatic wait_idle(int lim);
    int n;
    n = 0;
    while ((busy != 2'b00 || act[0] || act[1]) && n < lim) begin
      step(1);
      n++;
    end
    if (n >= lim) chk("idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic wait_k(int kk, int lim);
    int n;
    n = 0;
    while (k[0] != kk && n < lim) begin
      step(1);
      n++;
    end
    if (n >= lim) chk("k_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; syn = 1'b0;
    step(3);
    rst = 1'b0;
    chk_en = 1'b1;
    step(2);

    // full run, no early termination
    clr_cnt();
    start = 1'b1; step(1); start = 1'b0;
    wait_idle(2000);
    step(1);
    chk("a_loads", n_ld[0], 32);
    chk("a_stores", n_st[0], 32);
    chk("a_iters", n_f1[0], 2);
    chk("a_busy", n_busy[0], 164);
    chk("a_rstr", n_rr[0], 1);
    chk("a_done", n_done[0], 1);
    chk("a_iter_cnt", iter[0], 2);
    chk("a10_busy", n_busy[1], 2 + 10 * IT);
    chk("a10_iters", n_f1[1], 10);

    // start held high: back-to-back runs only via idle
    clr_cnt();
    start = 1'b1; step(900); start = 1'b0;
    wait_idle(2000);
    chk("b10_done", n_done[1], 2);

    // abort during WAIT of layer 5, iteration 0
    start = 1'b1; step(1); start = 1'b0;
    wait_k(2 + 5 * LP + 1, 200);
    abort = 1'b1; step(1); abort = 1'b0;
    chk("c_busy", busy, 2'b00);
    clr_cnt();
    step(20);
    chk("c_strobes", n_ld[0] + n_st[0] + n_f1[0] + n_done[0], 0);
    chk("c_layer", layer[0], 5);

    // reset during STORE of layer 0
    start = 1'b1; step(1); start = 1'b0;
    wait_k(LP + 1, 200);
    chk("d_in_store", st[0], 1);
    rst = 1'b1; step(1); rst = 1'b0;
    chk("d_store", st, 2'b00);
    chk("d_busy", busy, 2'b00);
    step(3);

    // syndrome satisfied at the first iteration end
    clr_cnt();
    syn = 1'b1;
    start = 1'b1; step(1); start = 1'b0;
    wait_idle(2000);
    syn = 1'b0;
    step(1);
    chk("e10_busy", n_busy[1], ET ? 2 + IT : 2 + 10 * IT);
    chk("e10_dok", dok[1], ET ? 1 : 0);
    chk("e10_iter", iter[1], ET ? 1 : 10);
    chk("e2_busy", n_busy[0], ET ? 2 + IT : 2 + 2 * IT);

    // random traffic
    for (int c = 0; c < 12000; c++) begin
      start = ($urandom % 20) == 0;
      syn = ($urandom % 4) == 0;
      abort = ($urandom % 800) == 0;
      rst = ($urandom % 1500) == 0;
      step(1);
    end
    start = 1'b0; syn = 1'b0; abort = 1'b0; rst = 1'b0;
    wait_idle(2000);
    step(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/r_layer_ctrl.md
# r_layer_ctrl

Layer/iteration sequencer for the layered QC-LDPC decoder. It is the initiator of the R-message memory handshake. Per layer it pulses `load_to_CNU` to read that layer's R messages into the CNU. After the CNU latency it pulses `storage` so the updated messages are written back at the same layer address. It pulses `f_one_iteration` to rewind the memory address after every full pass, and drives `rst_r` to clear the R memory at the start of each codeword.

## Interface
Parameters:
- `LAYERS`, 16: layers per iteration; must match the R memory depth (4-bit address).
- `MAX_ITER`, 10: maximum decoding iterations, ≥1.
- `CNU_LAT`, 3: cycles from `load_to_CNU` to valid CNU output, ≥1.
- `ITER_W`, 4: width of `iter_cnt`; must satisfy 2^ITER_W > MAX_ITER.

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: clock.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: begin decoding a codeword; honoured only in IDLE.
- `abort` in 1: synchronous abandon; returns to IDLE without `done`.
- `syndrome_ok` in 1: all parity checks satisfied; sampled only in ITER_END.
- `rst_r` out 1: active-low R-memory clear, low for exactly one cycle.
- `load_to_CNU` out 1: one-cycle read strobe for the current layer.
- `storage` out 1: one-cycle write strobe for the current layer.
- `f_one_iteration` out 1: one-cycle end-of-iteration strobe.
- `layer` out 4: current layer index.
- `iter_cnt` out ITER_W: number of completed iterations.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle completion pulse.
- `decode_ok` out 1: result flag; valid while `done` is high and held until the next `start`.

## Operation
- States: IDLE, CLEAR, LOAD, WAIT, STORE, ITER_END, DONE.
- IDLE, `start`=1: go to CLEAR. Clear `decode_ok`.
- CLEAR: `rst_r`=0. Set `layer`=0 and `iter_cnt`=0. Go to LOAD.
- LOAD: `load_to_CNU`=1. Load the wait counter with CNU_LAT−1. Go to WAIT.
- WAIT: stay while the counter is nonzero, decrementing each cycle. Stay exactly CNU_LAT cycles, then go to STORE.
- STORE: `storage`=1.
  - If `layer`==LAYERS−1: go to ITER_END.
  - Otherwise: `layer`++ and go to LOAD.
- ITER_END: `f_one_iteration`=1, `layer`=0, `iter_cnt`++.
  - If `iter_cnt`+1==MAX_ITER: go to DONE.
  - Otherwise: go to LOAD.
- DONE: `done`=1. Go to IDLE.
- `abort` has priority over every transition except `rst`. From any state other than IDLE it forces IDLE on the next edge. No `done` or `f_one_iteration` pulse is produced. `layer` and `iter_cnt` hold their values.
- `start` while `busy` is ignored.
- At most one of `load_to_CNU`, `storage`, `f_one_iteration` is high in any cycle. `rst_r` is never low outside CLEAR.

## Timing
- Reset values: state IDLE, `rst_r`=1, all strobes 0, `layer`=0, `iter_cnt`=0, `busy`=0, `done`=0, `decode_ok`=0.
- `rst` mid-operation returns all outputs to their reset values on the next edge, with no partial pulses.
- All outputs are registered and decoded from the state; no combinational path from input to output.
- Per layer: CNU_LAT+2 cycles (LOAD, WAIT×CNU_LAT, STORE).
- Per iteration: LAYERS·(CNU_LAT+2)+1 cycles.
- Full run: `done` is high 2+MAX_ITER·(LAYERS·(CNU_LAT+2)+1) cycles after the edge that samples `start`.
- `layer` is stable from LOAD through STORE of the same layer.
- `iter_cnt` updates on the edge leaving ITER_END.

## Configuration
- `R_EARLY_TERM_EN` defined:
  - In ITER_END, `syndrome_ok`=1 forces DONE regardless of `iter_cnt`.
  - `decode_ok` is set to 1 on entry to DONE.
  - `f_one_iteration` still pulses and `iter_cnt` still increments in that ITER_END.
- Undefined:
  - `syndrome_ok` is ignored.
  - Decoding always runs MAX_ITER iterations.
  - `decode_ok` stays 0.

## Test plan
- Reset, then `start` with LAYERS=16, CNU_LAT=3, MAX_ITER=2 → `rst_r` low 1 cycle; 32 `load_to_CNU` and 32 `storage` pulses, `storage` 4 cycles after each load; 2 `f_one_iteration` pulses; `done` 164 cycles after start, `iter_cnt`=2.
- Same configuration → `layer` sequence 0..15 twice; `storage` for layer 15 immediately followed by `f_one_iteration`; `layer` returns to 0.
- `start` held high throughout the run → exactly one run; a second run begins only from IDLE after `done`.
- `abort` during WAIT of layer 5, iteration 0 → IDLE next edge, `busy`=0, no `done`, no further strobes.
- `rst` pulsed during STORE → all outputs at reset values next cycle, no `storage` pulse that cycle.
- `R_EARLY_TERM_EN` defined, MAX_ITER=10, `syndrome_ok`=1 at the first ITER_END → `done` 83 cycles after start, `decode_ok`=1, `iter_cnt`=1.
  - With the macro undefined, the same stimulus → `done` after 10 iterations, `decode_ok`=0.
